pmem_burst_controller: RTL and testbench

Line-to-beat adapter directly downstream of the eviction write buffer / L2 physical-memory port. It accepts one full-line read or write request on the `pmem_*` handshake and serialises it into a command plus `LINE_BITS/BEAT_BITS` data beats on a narrow burst bus toward DRAM. For reads, it reassembles beats into a line and returns it with a one-cycle `pmem_resp`.

---
 rtl/pmem_burst_controller_pkg.sv | 28 ++
 rtl/pmem_burst_controller_beat_shifter.sv | 58 +++++
 rtl/pmem_burst_controller.sv | 200 ++++++++++++++++++++
 tb/tb_pmem_burst_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_burst_controller_pkg.sv
// Shared types for the line-to-beat burst adapter between the L2 pmem port and the DRAM burst bus.
// The optional watchdog is enabled with PMEM_BURST_TIMEOUT_EN.
package pmem_burst_controller_pkg;

    localparam int PMEM_ADDR_BITS    = 16;
    localparam int DEFAULT_LINE_BITS = 128;
    localparam int DEFAULT_BEAT_BITS = 32;

    typedef logic [DEFAULT_LINE_BITS-1:0] lc3b_pmem_data;
    typedef logic [DEFAULT_BEAT_BITS-1:0] lc3b_pmem_beat;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_RESP
    } pmem_burst_state_t;

    // Clears the byte-offset bits so the bus only ever sees line-aligned addresses.
    function automatic logic [PMEM_ADDR_BITS-1:0] line_align(
        input logic [PMEM_ADDR_BITS-1:0] addr,
        input int                        off_bits
    );
        return addr & (16'hFFFF << off_bits);
    endfunction

endpackage

// File: rtl/pmem_burst_controller_beat_shifter.sv
// pmem_beat_shifter: line register with beat-indexed write (read assembly),
// beat-indexed select (write serialisation) and the shared beat counter.
import pmem_burst_controller_pkg::*;

module pmem_beat_shifter #(
    parameter int LINE_BITS = 128,
    parameter int BEAT_BITS = 32,
    parameter int NBEATS    = LINE_BITS / BEAT_BITS,
    parameter int CNT_W     = $clog2(NBEATS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [LINE_BITS-1:0] load_line,
    input  logic                 beat_wr_en,
    input  logic [BEAT_BITS-1:0] beat_wdata,
    input  logic                 cnt_clr,
    input  logic                 cnt_inc,
    output logic [CNT_W-1:0]     cnt,
    output logic [LINE_BITS-1:0] line_merged,
    output logic [BEAT_BITS-1:0] beat_sel
);

    logic [LINE_BITS-1:0] line_q;

    // Counter values at or beyond NBEATS address no slot, so late beats are dropped.
    always_comb begin
        line_merged = line_q;
        beat_sel    = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
                beat_sel = line_q[i*BEAT_BITS +: BEAT_BITS];
                if (beat_wr_en) begin
                    line_merged[i*BEAT_BITS +: BEAT_BITS] = beat_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q <= '0;
            cnt    <= '0;
        end else begin
            if (load_en) begin
                line_q <= load_line;
            end else begin
                line_q <= line_merged;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc && (cnt != CNT_W'(NBEATS))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_burst_controller.sv
// Line-to-beat adapter: one pmem line request becomes a bus command plus NBEATS data beats.
// Define PMEM_BURST_TIMEOUT_EN to build the sticky watchdog that forces completion on a stuck bus.
import pmem_burst_controller_pkg::*;

// state | meaning
// IDLE  | waiting for pmem_read / pmem_write, request latched on accept
// CMD   | bus_cmd_valid high until bus_cmd_ready
// WDATA | presenting write beats, advance on bus_wready
// RDATA | collecting read beats until bus_rlast
// RESP  | one-cycle pmem_resp pulse
module pmem_burst_controller #(
    parameter int LINE_BITS      = 128,
    parameter int BEAT_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [15:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_resp,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 bus_cmd_valid,
    input  logic                 bus_cmd_ready,
    output logic                 bus_cmd_write,
    output logic [15:0]          bus_cmd_addr,
    output logic                 bus_wvalid,
    input  logic                 bus_wready,
    output logic [BEAT_BITS-1:0] bus_wdata,
    output logic                 bus_wlast,
    input  logic                 bus_rvalid,
    input  logic [BEAT_BITS-1:0] bus_rdata,
    input  logic                 bus_rlast,
    output logic                 bus_timeout
);

    localparam int NBEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W  = $clog2(NBEATS + 1);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);

    pmem_burst_state_t state, state_next;

    logic                 load_en;
    logic [LINE_BITS-1:0] load_line;
    logic                 beat_wr_en;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic [CNT_W-1:0]     cnt;
    logic [LINE_BITS-1:0] line_merged;
    logic [BEAT_BITS-1:0] beat_sel;
    logic                 rdata_load;
    logic                 wd_hit;
    logic                 cmd_write_q;
    logic [15:0]          cmd_addr_q;
    logic [LINE_BITS-1:0] rdata_q;

    pmem_beat_shifter #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS),
        .NBEATS    (NBEATS),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_line   (load_line),
        .beat_wr_en  (beat_wr_en),
        .beat_wdata  (bus_rdata),
        .cnt_clr     (cnt_clr),
        .cnt_inc     (cnt_inc),
        .cnt         (cnt),
        .line_merged (line_merged),
        .beat_sel    (beat_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        load_line  = pmem_wdata;
        beat_wr_en = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        rdata_load = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (pmem_write) begin
                    load_en    = 1'b1;
                    state_next = ST_CMD;
                end else if (pmem_read) begin
                    // Seed with the last read line so slots a short burst never fills keep old data.
                    load_en    = 1'b1;
                    load_line  = rdata_q;
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                cnt_clr = 1'b1;
                if (bus_cmd_ready) begin
                    state_next = cmd_write_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (bus_wready) begin
                    cnt_inc = 1'b1;
                    if (cnt == CNT_W'(NBEATS - 1)) begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RDATA: begin
                if (bus_rvalid) begin
                    beat_wr_en = 1'b1;
                    cnt_inc    = 1'b1;
                    if (bus_rlast) begin
                        rdata_load = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (wd_hit) begin
            state_next = ST_RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            rdata_q     <= '0;
        end else begin
            if ((state == ST_IDLE) && (pmem_write || pmem_read)) begin
                cmd_write_q <= pmem_write;
                cmd_addr_q  <= line_align(pmem_address, OFF_W);
            end
            if (rdata_load) begin
                rdata_q <= line_merged;
            end
        end
    end

`ifdef PMEM_BURST_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_q;
    logic            wd_active;
    logic            timeout_q;

    assign wd_active = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_RDATA);
    assign wd_hit    = wd_active && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                wd_q <= '0;
            end else if (wd_active) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus_timeout = timeout_q;
`else
    // Without the watchdog the FSM waits indefinitely; the compare is constant false.
    assign wd_hit      = (TIMEOUT_CYCLES < 0);
    assign bus_timeout = 1'b0;
`endif

    assign pmem_resp     = (state == ST_RESP);
    assign pmem_rdata    = rdata_q;
    assign bus_cmd_valid = (state == ST_CMD);
    assign bus_cmd_write = cmd_write_q;
    assign bus_cmd_addr  = cmd_addr_q;
    assign bus_wvalid    = (state == ST_WDATA);
    assign bus_wlast     = (state == ST_WDATA) && (cnt == CNT_W'(NBEATS - 1));
    assign bus_wdata     = beat_sel;

endmodule

// File: tb/tb_pmem_burst_controller.sv
// Directed bench for pmem_burst_controller: table of line transactions plus hand-written
// sequences for simultaneous requests, reset mid-burst and the PMEM_BURST_TIMEOUT_EN watchdog.
module tb_pmem_burst_controller;

    logic         clk;
    logic         reset;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         bus_cmd_valid;
    logic         bus_cmd_ready;
    logic         bus_cmd_write;
    logic [15:0]  bus_cmd_addr;
    logic         bus_wvalid;
    logic         bus_wready;
    logic [31:0]  bus_wdata;
    logic         bus_wlast;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;
    logic         bus_rlast;
    logic         bus_timeout;

    int tests = 0;
    int fails = 0;

    pmem_burst_controller #(
        .LINE_BITS      (128),
        .BEAT_BITS      (32),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_cmd_ready (bus_cmd_ready),
        .bus_cmd_write (bus_cmd_write),
        .bus_cmd_addr  (bus_cmd_addr),
        .bus_wvalid    (bus_wvalid),
        .bus_wready    (bus_wready),
        .bus_wdata     (bus_wdata),
        .bus_wlast     (bus_wlast),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_rlast     (bus_rlast),
        .bus_timeout   (bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rd_lat: cycles from the command-accept cycle to the first read beat.
    typedef struct {
        bit           is_write;
        logic [15:0]  addr;
        logic [127:0] line;
        int           stall_beat;
        int           stall_n;
        int           rd_lat;
        int           rd_beats;
        logic [31:0]  rd_base;
        logic [15:0]  exp_addr;
        logic [127:0] exp_rdata;
        int           exp_resp_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        bus_rvalid = 1'b0;
        bus_rlast = 1'b0;
        bus_cmd_ready = 1'b1;
        bus_wready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // which: 0 = bus_cmd_valid, 1 = pmem_resp; bounded wait on negedges.
    task automatic wait_for(input int which, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((which == 0 && bus_cmd_valid) || (which == 1 && pmem_resp)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_wait"}, 0, 1);
    endtask

    // Call at a negedge in an IDLE cycle; returns at the negedge of the cycle after RESP.
    task automatic run_txn(input vec_t v, input string tag);
        int beat, stall_left, cmd_cyc, resp_cyc, resp_cnt, i;
        beat = 0; stall_left = v.stall_n; cmd_cyc = -1; resp_cyc = -1; resp_cnt = 0;
        pmem_write = v.is_write;
        pmem_read = !v.is_write;
        pmem_address = v.addr;
        pmem_wdata = v.line;
        bus_cmd_ready = 1'b1;
        bus_wready = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            bus_rlast = 1'b0;
            bus_rdata = '0;
            if (bus_cmd_valid && cmd_cyc < 0) begin
                cmd_cyc = cyc;
                check({tag, "_cmd_addr"}, bus_cmd_addr, v.exp_addr);
                check({tag, "_cmd_write"}, bus_cmd_write, v.is_write);
            end
            if (bus_wvalid) begin
                if (beat < 4) begin
                    check({tag, "_wdata"}, bus_wdata, v.line[beat*32 +: 32]);
                    check({tag, "_wlast"}, bus_wlast, beat == 3);
                end else begin
                    check({tag, "_extra_beat"}, beat, 3);
                end
                if (beat == v.stall_beat && stall_left > 0) begin
                    bus_wready = 1'b0;
                    stall_left--;
                end else begin
                    bus_wready = 1'b1;
                    beat++;
                end
            end
            if (!v.is_write && cmd_cyc > 0 && cyc >= cmd_cyc + v.rd_lat
                && cyc < cmd_cyc + v.rd_lat + v.rd_beats) begin
                i = cyc - cmd_cyc - v.rd_lat;
                bus_rvalid = 1'b1;
                bus_rdata = v.rd_base + 32'(i);
                bus_rlast = (i == v.rd_beats - 1);
            end
            if (pmem_resp) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc;
                    check({tag, "_rdata"}, pmem_rdata, v.exp_rdata);
                    pmem_read = 1'b0;
                    pmem_write = 1'b0;
                end
            end
            if (resp_cyc > 0 && cyc == resp_cyc + 1) break;
        end
        check({tag, "_resp_cycle"}, resp_cyc, v.exp_resp_cyc);
        check({tag, "_resp_pulses"}, resp_cnt, 1);
        if (v.is_write) check({tag, "_beats"}, beat, 4);
        check({tag, "_rdata_hold"}, pmem_rdata, v.exp_rdata);
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        bus_wready = 1'b1;
    endtask

    initial begin
        vec_t v;
        int resp_cyc;

        vecs[0] = '{1'b1, 16'h1230, 128'h0F0E0D0C_0B0A0908_07060504_03020100, -1, 0, 0, 0,
                    32'h0, 16'h1230, 128'h0, 6};
        vecs[1] = '{1'b0, 16'h4008, 128'h0, -1, 0, 3, 4, 32'hAAAA0000, 16'h4000,
                    128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 8};
        vecs[2] = '{1'b1, 16'h7FFF, 128'h11111111_22222222_33333333_44444444, 2, 5, 0, 0,
                    32'h0, 16'h7FF0, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 11};
        // rlast on the 2nd beat: slots 2 and 3 keep the previous read line.
        vecs[3] = '{1'b0, 16'h0ABC, 128'h0, -1, 0, 3, 2, 32'hBBBB0000, 16'h0AB0,
                    128'hAAAA0003_AAAA0002_BBBB0001_BBBB0000, 6};
        // rlast on a 5th beat: the extra beat is dropped.
        vecs[4] = '{1'b0, 16'hFFFF, 128'h0, -1, 0, 1, 5, 32'hCCCC0000, 16'hFFF0,
                    128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000, 7};

        reset = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        bus_cmd_ready = 1'b1;
        bus_wready = 1'b1;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        bus_rlast = 1'b0;

        @(negedge clk);
        check("reset_resp", pmem_resp, 0);
        check("reset_cmd_valid", bus_cmd_valid, 0);
        check("reset_wvalid", bus_wvalid, 0);
        check("reset_wlast", bus_wlast, 0);
        check("reset_rdata", pmem_rdata, 0);
        check("reset_cmd_addr", bus_cmd_addr, 0);
        check("reset_timeout", bus_timeout, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            run_txn(vecs[k], $sformatf("vec%0d", k));
        end

        // Read and write together: write first, read served after RESP and an IDLE cycle.
        pmem_read = 1'b1;
        pmem_write = 1'b1;
        pmem_address = 16'h2040;
        pmem_wdata = 128'h55555555_66666666_77777777_88888888;
        wait_for(0, "both_cmd1");
        check("both_first_write", bus_cmd_write, 1);
        check("both_first_addr", bus_cmd_addr, 16'h2040);
        wait_for(1, "both_resp1");
        pmem_write = 1'b0;
        @(negedge clk);
        check("both_idle_gap", bus_cmd_valid, 0);
        wait_for(0, "both_cmd2");
        check("both_second_write", bus_cmd_write, 0);
        check("both_second_addr", bus_cmd_addr, 16'h2040);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid = 1'b1;
            bus_rdata = 32'hDDDD0000 + 32'(i);
            bus_rlast = (i == 3);
        end
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_rlast = 1'b0;
        check("both_read_resp", pmem_resp, 1);
        check("both_read_rdata", pmem_rdata, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000);
        pmem_read = 1'b0;
        @(negedge clk);

        // Reset asserted asynchronously while beat 1 of a read is on the bus.
        pmem_read = 1'b1;
        pmem_address = 16'h5000;
        wait_for(0, "rst_cmd");
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata = 32'hE0E0E0E0;
        @(negedge clk);
        bus_rdata = 32'hE1E1E1E1;
        #2 reset = 1'b1;
        #1;
        check("midrst_resp", pmem_resp, 0);
        check("midrst_rdata", pmem_rdata, 0);
        check("midrst_cmd_valid", bus_cmd_valid, 0);
        check("midrst_cmd_addr", bus_cmd_addr, 0);
        check("midrst_wvalid", bus_wvalid, 0);
        check("midrst_wlast", bus_wlast, 0);
        do_reset();
        @(negedge clk);
        v = '{1'b0, 16'h6010, 128'h0, -1, 0, 2, 4, 32'hFFFF0000, 16'h6010,
              128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000, 7};
        run_txn(v, "post_reset_read");

        // Command never accepted.
        pmem_read = 1'b1;
        pmem_address = 16'h3000;
        bus_cmd_ready = 1'b0;
`ifdef PMEM_BURST_TIMEOUT_EN
        resp_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (pmem_resp) begin
                resp_cyc = cyc;
                break;
            end
        end
        check("wd_resp_cycle", resp_cyc, 11);
        check("wd_flag_set", bus_timeout, 1);
        check("wd_stale_rdata", pmem_rdata, 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000);
        pmem_read = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_flag_sticky", bus_timeout, 1);
        check("wd_back_idle", bus_cmd_valid, 0);
        do_reset();
        @(negedge clk);
        check("wd_flag_cleared", bus_timeout, 0);
`else
        resp_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (pmem_resp) resp_cyc++;
        end
        check("stuck_cmd_valid", bus_cmd_valid, 1);
        check("stuck_no_resp", resp_cyc, 0);
        check("stuck_no_timeout", bus_timeout, 0);
        do_reset();
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
